spi_memory_slave: RTL
=====================

SPI_MEMORY_SLAVE -- requirements
Module: spi_memory_slave

Interface
REQ-001 Parameter ADDR_BYTES, default 3: address bytes per command.
REQ-002 Parameter JEDEC_ID, default 24'hEF4017: value returned by opcode 0x9F.
REQ-003 Parameter FAST_DUMMY, default 8: dummy SCK cycles for opcode 0x0B.
REQ-004 main_clock  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 sck  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous to main_clock.
REQ-007 cs  in  1  chip select, active low.
REQ-008 mosi  in  1  master-to-slave data, MSB first.
REQ-009 miso  out  1  slave-to-master data, MSB first.
REQ-010 miso_oe  out  1  high while the slave drives read or ID data.
REQ-011 mem_addr  out  8*ADDR_BYTES  memory word address.
REQ-012 mem_rd  out  1  one-cycle read strobe.
REQ-013 mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd.
REQ-014 mem_wr  out  1  one-cycle write strobe.
REQ-015 mem_wdata  out  8  write data, valid with mem_wr.
REQ-016 busy  out  1  high from cs falling edge until return to IDLE.
REQ-017 state_out  out  4  current state encoding, for debug.

Function
REQ-018 sck, cs and mosi shall each pass through a 2-flop synchronizer; sck edges are detected on the synchronized signal; sck frequency shall not exceed main_clock/8.
REQ-019 States: IDLE=0, OPCODE=1, ADDR=2, DUMMY=3, READ=4, WRITE=5, ID=6, IGNORE=7.
REQ-020 IDLE -> OPCODE on synchronized cs falling edge; bit counter cleared.
REQ-021 mosi shall be sampled on each synchronized sck rising edge into a shift register, MSB first.
REQ-022 After 8 opcode bits: 0x03 or 0x0B -> ADDR (read); 0x02 -> ADDR (write); 0x9F -> ID; any other value -> IGNORE.
REQ-023 ADDR shall collect 8*ADDR_BYTES bits into mem_addr; afterwards 0x0B -> DUMMY, 0x03 -> READ, 0x02 -> WRITE.
REQ-024 DUMMY shall count FAST_DUMMY sck rising edges, then enter READ.
REQ-025 On entering READ, mem_rd shall pulse once; mem_rdata captured the next cycle is loaded into the output shifter before the next sck falling edge.
REQ-026 In READ/ID, miso shall update on each synchronized sck falling edge; the first bit of every byte is its bit 7.
REQ-027 After the 8th falling edge of a read byte, mem_addr increments, mem_rd pulses and the next byte is loaded; reads continue indefinitely while cs is low.
REQ-028 In WRITE, each completed 8-bit group shall produce one mem_wr pulse with the current mem_addr and mem_wdata, then mem_addr increments.
REQ-029 mem_addr shall wrap from all-ones to zero.
REQ-030 ID shall shift out JEDEC_ID MSB first, then repeat it while cs stays low.
REQ-031 IGNORE shall keep miso_oe low, produce no memory strobes, and wait for cs high.
REQ-032 Synchronized cs rising edge in any state shall return to IDLE within 1 cycle; a partial write byte is discarded, miso_oe goes low, busy goes low.
REQ-033 A cs rising edge coinciding with a byte-completing sck edge shall still issue that byte's mem_wr.
REQ-034 miso shall be 0 whenever miso_oe is low.

Reset
REQ-035 On reset: state=IDLE, miso=0, miso_oe=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, busy=0, counters and synchronizers cleared (cs synchronizer to 1).
REQ-036 Reset asserted mid-transfer shall abort without any memory strobe; after release, the slave waits for a fresh cs falling edge.

Structure
REQ-037 Package spi_memory_pkg shall hold opcode constants (0x03, 0x0B, 0x02, 0x9F) and the state encodings.
REQ-038 Sub-module spi_input_sync shall implement the synchronizers and the sck rise/fall and cs fall/rise edge pulses.

Verification
REQ-039 READ 0x03 at address 0x000010, memory[0x10..0x11]=0xA5,0x3C, 16 data clocks -> miso bytes 0xA5, 0x3C; mem_rd pulses with addresses 0x10 and 0x11.
REQ-040 FAST READ 0x0B at 0x000000, 8 dummy clocks -> first byte equals memory[0]; no miso_oe during dummy cycles.
REQ-041 PROGRAM 0x02 at 0xFFFFFF with data 0x11,0x22 -> mem_wr at 0xFFFFFF with 0x11, then at 0x000000 with 0x22.
REQ-042 0x9F followed by 48 clocks -> miso 0xEF,0x40,0x17,0xEF,0x40,0x17.
REQ-043 PROGRAM with 12 data bits then cs high -> exactly one mem_wr; state_out=0 within 3 cycles.
REQ-044 Opcode 0x55, and separately reset asserted mid-address -> no strobes, miso_oe=0, busy low after cs high/reset.

Source files
------------

// File: rtl/spi_memory_pkg.sv
// Shared opcodes and FSM state encodings for the SPI memory slave.
// Latency: none (definitions only).
// Backpressure: not applicable.
package spi_memory_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_PROGRAM   = 8'h02;
    localparam logic [7:0] OP_JEDEC_ID  = 8'h9F;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_OPCODE = 4'd1,
        ST_ADDR   = 4'd2,
        ST_DUMMY  = 4'd3,
        ST_READ   = 4'd4,
        ST_WRITE  = 4'd5,
        ST_ID     = 4'd6,
        ST_IGNORE = 4'd7
    } state_t;

endpackage

// File: rtl/spi_memory_slave_if.sv
// SPI pins, memory port and status bundled between the slave and its environment.
// Latency: none (wiring only).
// Backpressure: none; the memory answers a read one cycle after mem_rd.
interface spi_memory_slave_if #(
    parameter int ADDR_BYTES = 3
);
    logic                    sck;
    logic                    cs;
    logic                    mosi;
    logic                    miso;
    logic                    miso_oe;
    logic [8*ADDR_BYTES-1:0] mem_addr;
    logic                    mem_rd;
    logic [7:0]              mem_rdata;
    logic                    mem_wr;
    logic [7:0]              mem_wdata;
    logic                    busy;
    logic [3:0]              state_out;

    modport slave (
        input  sck, cs, mosi, mem_rdata,
        output miso, miso_oe, mem_addr, mem_rd, mem_wr, mem_wdata, busy, state_out
    );

    modport master (
        output sck, cs, mosi, mem_rdata,
        input  miso, miso_oe, mem_addr, mem_rd, mem_wr, mem_wdata, busy, state_out
    );
endinterface

// File: rtl/spi_input_sync.sv
// Two-flop synchronizers for sck/cs/mosi plus sck rise/fall and cs fall/rise pulses.
// Latency: 2 main clock cycles from pin to synchronized level and edge pulse.
// Backpressure: none; sck must stay at or below main_clock/8.
module spi_input_sync (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic cs,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s
);
    // [0] first flop, [1] synchronized level, [2] previous synchronized level
    logic [2:0] sck_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    // Shift the pins through the synchronizer chains; cs idles high so no edge fires out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q  <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            cs_q   <= {cs_q[1:0], cs};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    // mosi has the same chain depth as sck, so mosi_s is the value present at the sampled sck edge
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign mosi_s   = mosi_q[1];
endmodule

// File: rtl/spi_memory_slave.sv
// SPI mode-0 serial memory slave: READ, FAST READ, PROGRAM and JEDEC ID over a byte memory port.
// Latency: 2-cycle input sync; mem_rd issues 1 cycle after the byte-ending sck edge, data loaded 2 cycles later.
// Backpressure: none; the master paces everything via sck, memory must answer one cycle after mem_rd.
module spi_memory_slave
    import spi_memory_pkg::*;
#(
    parameter int          ADDR_BYTES = 3,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4017,
    parameter int          FAST_DUMMY = 8
) (
    input logic                main_clock,
    input logic                reset,
    spi_memory_slave_if.slave  bus
);
    localparam int AW = 8 * ADDR_BYTES;

    logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

    spi_input_sync u_sync (
        .clk      (main_clock),
        .rst      (reset),
        .sck      (bus.sck),
        .cs       (bus.cs),
        .mosi     (bus.mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .mosi_s   (mosi_s)
    );

    state_t          state;
    logic [7:0]      shift_in;
    logic [7:0]      opcode;
    logic [7:0]      out_shift;
    logic [7:0]      wdata;
    logic [AW-1:0]   addr;
    logic [15:0]     cnt;
    logic [2:0]      bit_cnt;
    logic [1:0]      id_idx;
    logic            rd, rd_q, wr, miso_r, oe_r, busy_r;
    logic [7:0]      in_byte;

    assign in_byte = {shift_in[6:0], mosi_s};

    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return JEDEC_ID[23:16];
            2'd1:    return JEDEC_ID[15:8];
            default: return JEDEC_ID[7:0];
        endcase
    endfunction

    // Command FSM: decodes the serial stream and drives the memory strobes and miso shifter
    always_ff @(posedge main_clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            shift_in  <= '0;
            opcode    <= '0;
            out_shift <= '0;
            wdata     <= '0;
            addr      <= '0;
            cnt       <= '0;
            bit_cnt   <= '0;
            id_idx    <= '0;
            rd        <= 1'b0;
            rd_q      <= 1'b0;
            wr        <= 1'b0;
            miso_r    <= 1'b0;
            oe_r      <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            rd   <= 1'b0;
            wr   <= 1'b0;
            rd_q <= rd;
            // Address advances the cycle after a write strobe so mem_addr is stable while mem_wr is high
            if (wr) addr <= addr + AW'(1);

            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state   <= ST_OPCODE;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_OPCODE: begin
                    if (sck_rise) begin
                        shift_in <= in_byte;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            opcode  <= in_byte;
                            bit_cnt <= '0;
                            cnt     <= '0;
                            case (in_byte)
                                OP_READ, OP_FAST_READ, OP_PROGRAM: state <= ST_ADDR;
                                OP_JEDEC_ID: begin
                                    state     <= ST_ID;
                                    out_shift <= id_byte(2'd0);
                                    id_idx    <= 2'd1;
                                end
                                default: state <= ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        addr <= {addr[AW-2:0], mosi_s};
                        cnt  <= cnt + 16'd1;
                        if (cnt == 16'(AW - 1)) begin
                            cnt     <= '0;
                            bit_cnt <= '0;
                            if (opcode == OP_PROGRAM) begin
                                state <= ST_WRITE;
                            end else if (opcode == OP_FAST_READ && FAST_DUMMY > 0) begin
                                state <= ST_DUMMY;
                            end else begin
                                state <= ST_READ;
                                rd    <= 1'b1;
                            end
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sck_rise) begin
                        cnt <= cnt + 16'd1;
                        if (cnt == 16'(FAST_DUMMY - 1)) begin
                            state   <= ST_READ;
                            rd      <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                end
                ST_READ: begin
                    if (sck_fall) begin
                        miso_r    <= out_shift[7];
                        oe_r      <= 1'b1;
                        out_shift <= {out_shift[6:0], 1'b0};
                        bit_cnt   <= bit_cnt + 3'd1;
                        // Last bit of the byte is on the wire: prefetch the next one
                        if (bit_cnt == 3'd7) begin
                            addr <= addr + AW'(1);
                            rd   <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (sck_rise) begin
                        shift_in <= in_byte;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            wr    <= 1'b1;
                            wdata <= in_byte;
                        end
                    end
                end
                ST_ID: begin
                    if (sck_fall) begin
                        miso_r    <= out_shift[7];
                        oe_r      <= 1'b1;
                        out_shift <= {out_shift[6:0], 1'b0};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            out_shift <= id_byte(id_idx);
                            id_idx    <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                        end
                    end
                end
                ST_IGNORE: begin
                    // Unknown opcode: stay silent until the master deselects
                end
                default: state <= ST_IDLE;
            endcase

            // Deselect wins over any state change but leaves a just-completed write strobe intact
            if (cs_rise) begin
                state  <= ST_IDLE;
                miso_r <= 1'b0;
                oe_r   <= 1'b0;
                busy_r <= 1'b0;
            end

            // Memory returns data one cycle after the strobe; load it for the next falling edge
            if (rd_q) out_shift <= bus.mem_rdata;
        end
    end

    assign bus.miso      = miso_r;
    assign bus.miso_oe   = oe_r;
    assign bus.mem_addr  = addr;
    assign bus.mem_rd    = rd;
    assign bus.mem_wr    = wr;
    assign bus.mem_wdata = wdata;
    assign bus.busy      = busy_r;
    assign bus.state_out = state;
endmodule
